// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer and the enable-gated ALU it feeds.
package alu_seq_pkg;

    // Default datapath widths.
    localparam int unsigned AluW   = 4;
    localparam int unsigned AluOpW = 3;

    // Opcodes understood by the shared ALU.
    localparam logic [AluOpW-1:0] OpAdd   = 3'd0;
    localparam logic [AluOpW-1:0] OpSub   = 3'd1;
    localparam logic [AluOpW-1:0] OpAnd   = 3'd2;
    localparam logic [AluOpW-1:0] OpOr    = 3'd3;
    localparam logic [AluOpW-1:0] OpXor   = 3'd4;
    localparam logic [AluOpW-1:0] OpPassA = 3'd5;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } seq_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; the priority bit flips away from each winner.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid0_i,
    input  logic       valid1_i,
    input  logic       advance_i,
    output logic [1:0] gnt_o
);

    logic pri_q, pri_d;

    // One-hot grant: a lone requester wins, a tie goes to the priority holder.
    always_comb begin
        gnt_o[0] = valid0_i & (~valid1_i | ~pri_q);
        gnt_o[1] = valid1_i & (~valid0_i | pri_q);
    end

    // Priority moves to the loser only when a grant is actually taken.
    always_comb begin
        pri_d = pri_q;
        if (advance_i && (gnt_o != 2'b00)) begin
            pri_d = ~gnt_o[1];
        end
    end

    // Priority register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pri_q <= 1'b0;
        end else begin
            pri_q <= pri_d;
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Two-requester controller for the shared ALU: arbitrate, gate operands for a
// fixed window, capture the result and return it over a valid/ready channel.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned W       = AluW,
    parameter int unsigned OPW     = AluOpW,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [W-1:0]   req0_a,
    input  logic [W-1:0]   req0_b,
    input  logic [OPW-1:0] req0_op,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [W-1:0]   req1_a,
    input  logic [W-1:0]   req1_b,
    input  logic [OPW-1:0] req1_op,
    output logic           alu_en,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    output logic [OPW-1:0] alu_op,
    input  logic [W-1:0]   alu_result,
    input  logic           alu_carry,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [W-1:0]   rsp_result,
    output logic           rsp_carry,
    output logic           busy
);

    localparam int unsigned    CntW    = $clog2(ALU_LAT + 1);
    localparam logic [CntW-1:0] CntLoad = CntW'(ALU_LAT - 1);

    seq_state_e     state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic           alu_en_q, alu_en_d;
    logic [W-1:0]   alu_a_q, alu_a_d;
    logic [W-1:0]   alu_b_q, alu_b_d;
    logic [OPW-1:0] alu_op_q, alu_op_d;
    logic           id_q, id_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic           rsp_id_q, rsp_id_d;
    logic [W-1:0]   rsp_result_q, rsp_result_d;
    logic           rsp_carry_q, rsp_carry_d;

    logic [1:0] gnt;
    logic       accept;

    assign accept = (state_q == StIdle) & (req0_valid | req1_valid);

    rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .valid0_i  (req0_valid),
        .valid1_i  (req1_valid),
        .advance_i (accept),
        .gnt_o     (gnt)
    );

    // Next-state: accept in IDLE, count out the window in EXEC, hand off in RESP.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        alu_en_d     = alu_en_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        id_d         = id_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_carry_d  = rsp_carry_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d  = StExec;
                    cnt_d    = CntLoad;
                    alu_en_d = 1'b1;
                    alu_a_d  = gnt[1] ? req1_a  : req0_a;
                    alu_b_d  = gnt[1] ? req1_b  : req0_b;
                    alu_op_d = gnt[1] ? req1_op : req0_op;
                    id_d     = gnt[1];
                end
            end
            StExec: begin
                if (cnt_q == '0) begin
                    state_d      = StResp;
                    rsp_valid_d  = 1'b1;
                    rsp_id_d     = id_q;
                    rsp_result_d = alu_result;
                    rsp_carry_d  = alu_carry;
                    // Drop the gate so operands read zero outside the window.
                    alu_en_d     = 1'b0;
                    alu_a_d      = '0;
                    alu_b_d      = '0;
                    alu_op_d     = '0;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d     = StIdle;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and registered outputs; reset discards any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            alu_en_q     <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            id_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_carry_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            alu_en_q     <= alu_en_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            id_q         <= id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_carry_q  <= rsp_carry_d;
        end
    end

    assign req0_ready = (state_q == StIdle) & gnt[0];
    assign req1_ready = (state_q == StIdle) & gnt[1];
    assign alu_en     = alu_en_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_carry  = rsp_carry_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Two-requester controller for the shared 4-bit ALU.
- Arbitrates round-robin between two operation requesters.
- Latches the winner's operands and opcode, then drives the ALU operand-gate enable (the `D` input of the operand enable stage) for a fixed execution window.
- Captures the ALU result and returns it with the requester ID over a valid/ready response channel.
- Sits between the front-end issue logic and the enable-gated ALU datapath.

## Interface

Parameters:
- W, 4, operand/result width
- OPW, 3, ALU opcode width
- ALU_LAT, 1, cycles the operand gate must be held before the result is sampled (≥1)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 accepted this cycle
- req0_a, req0_b  in  W  requester 0 operands
- req0_op  in  OPW  requester 0 opcode
- req1_valid, req1_ready, req1_a, req1_b, req1_op  as req0, for requester 1
- alu_en  out  1  operand gate enable, drives `D` of the enable stage
- alu_a, alu_b  out  W  latched operands to the enable stage
- alu_op  out  OPW  opcode to the ALU
- alu_result  in  W  ALU result
- alu_carry  in  1  ALU carry/borrow out
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester that issued the operation
- rsp_result  out  W  captured result
- rsp_carry  out  1  captured carry
- busy  out  1  state ≠ IDLE

## Operation

- States: IDLE, EXEC, RESP.
- IDLE:
  - Arbitrate. Handshake with the winner: reqN_ready=1 combinationally, only when state=IDLE and N is granted.
  - On accept, latch a, b, op and id; load the counter with ALU_LAT−1; go to EXEC.
  - No valid request: stay in IDLE.
- EXEC:
  - alu_en=1; alu_a/alu_b/alu_op hold the latched values.
  - Counter decrements each cycle.
  - In the cycle the counter reads 0: capture alu_result/alu_carry into the rsp registers and go to RESP.
- RESP:
  - rsp_valid=1; rsp_id/rsp_result/rsp_carry held stable.
  - On rsp_valid&&rsp_ready, go to IDLE.
  - No new request is accepted in the same cycle.
- Outside EXEC: alu_en=0 and alu_a/alu_b/alu_op=0, so the gated operands are zero.
- Arbitration:
  - Priority bit pri, reset 0 (requester 0 preferred).
  - Both valid: winner = pri.
  - One valid: that one wins.
  - After any grant: pri ← ~winner.
  - pri does not change without a grant.
- Requesters hold valid and payload stable until ready. Payload changes while waiting are tolerated; the value sampled at accept is the one used.
- Reset values: state=IDLE, pri=0, counter=0, all rsp registers 0, all outputs 0.
- Reset mid-operation (EXEC or RESP) discards the operation. No response is produced and no ready is re-issued.

## Timing

- Accept at cycle t (IDLE).
- EXEC from t+1 to t+ALU_LAT: alu_en high for exactly ALU_LAT cycles.
- Result sampled at the clock edge ending cycle t+ALU_LAT.
- rsp_valid from t+ALU_LAT+1.
- Earliest next accept: the cycle after the response handshake. Minimum issue interval is ALU_LAT+2 cycles.
- rsp_ready held low: the block stays in RESP indefinitely; both reqN_ready stay 0.
- rsp_ready high before rsp_valid: no effect.
- Counter width: clog2(ALU_LAT+1).
- ALU_LAT=1: a single EXEC cycle.

## Structure

- Package alu_seq_pkg holds:
  - the state enum (IDLE, EXEC, RESP)
  - default W and OPW constants
  - ALU opcode localparams shared with the ALU
- Sub-module rr_arb2:
  - Two-input round-robin arbiter: inputs valid0/valid1 and an advance strobe; outputs a one-hot grant.
  - Owns the pri register.
- The FSM, counter and capture registers stay in alu_sequencer.

## Test plan

- Reset, then single request: req0 valid, a=4'h3, b=4'h5, op=ADD, ALU_LAT=1.
  - Ready in cycle t; alu_en=1 only in t+1 with alu_a=3, alu_b=5.
  - rsp_valid at t+2 with rsp_id=0, rsp_result=4'h8, rsp_carry=0.
- Contention: both valid continuously with rsp_ready=1.
  - Grants alternate 0,1,0,1 starting with 0.
  - rsp_id sequence matches; no request is starved.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid.
  - rsp fields stay stable; req ready stays 0; alu_en stays 0.
  - Accept occurs the cycle after rsp_ready rises.
- Latency: ALU_LAT=3 with a=4'hF, b=4'h1, ADD.
  - alu_en high exactly 3 cycles.
  - rsp_result=4'h0, rsp_carry=1.
- Reset mid-EXEC: assert rst during EXEC.
  - Next cycle state is IDLE, alu_en=0, rsp_valid=0, pri=0.
  - No response for the aborted operation.
- Idle gating: no requests for 10 cycles.
  - alu_en=0, alu_a=alu_b=0, busy=0 throughout.
